// File: rtl/seq_det_pkg.sv
// Shared types and the prefix/suffix step rule for the 1101 sequence-detector scheduler.
// The step rule is evaluated at elaboration to fill the engine's next-state table.
package seq_det_pkg;

    localparam int MAX_PAT_W = 8;
    localparam int ST_W      = $clog2(MAX_PAT_W);
    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

    // i-th pattern bit in arrival order (i = 0 is the MSB, received first)
    function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int pat_w, input int i);
        logic [MAX_PAT_W-1:0] t;
        t = pat >> (pat_w - 1 - i);
        return t[0];
    endfunction

    function automatic logic [ST_W-1:0] next_state(
        input logic [ST_W-1:0]      st,
        input logic                 b,
        input logic                 overlap,
        input logic [MAX_PAT_W-1:0] pat,
        input int                   pat_w
    );
        logic [MAX_PAT_W-1:0] seq;
        logic [MAX_PAT_W-1:0] t;
        int                   len;
        int                   best;
        logic                 ok;
        seq = '0;
        for (int i = 0; i < MAX_PAT_W; i++) begin
            if (i < int'(st)) begin
                seq = seq | ({{(MAX_PAT_W-1){1'b0}}, pat_bit(pat, pat_w, i)} << i);
            end
        end
        seq = seq | ({{(MAX_PAT_W-1){1'b0}}, b} << st);
        len = int'(st) + 1;
        if (len == pat_w && b == pat[0] && !overlap) begin
            return '0;
        end
        // Longest proper suffix of the received string that is also a pattern prefix;
        // on a full match this is the pattern's longest proper border.
        best = 0;
        for (int k = 1; k < MAX_PAT_W; k++) begin
            if (k <= len && k < pat_w) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PAT_W; j++) begin
                    if (j < k) begin
                        t = seq >> (len - k + j);
                        if (t[0] != pat_bit(pat, pat_w, j)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return ST_W'(best);
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Combinational single-step Mealy engine: (state, bit) -> (next state, hit).
// Define SEQ_DET_OVERLAP_EN to restart from the pattern border after a hit instead of S0.
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic [ST_W-1:0] st,
    input  logic            bit_in,
    output logic [ST_W-1:0] next_st,
    output logic            hit
);

`ifdef SEQ_DET_OVERLAP_EN
    localparam logic OVERLAP = 1'b1;
`else
    localparam logic OVERLAP = 1'b0;
`endif

    localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);

    // Table indexed by {state, bit}; unreachable states fall back to S0
    logic [ST_W-1:0] lut [2**(ST_W+1)];

    for (genvar s = 0; s < 2**ST_W; s++) begin : g_st
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (s < PAT_W) begin : g_live
                assign lut[2*s+b] = next_state(ST_W'(s), (b != 0), OVERLAP, PAT_EXT, PAT_W);
            end else begin : g_dead
                assign lut[2*s+b] = '0;
            end
        end
    end

    always_comb begin
        hit     = (int'(st) == PAT_W - 1) && (bit_in == PATTERN[0]);
        next_st = lut[{st, bit_in}];
    end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one sequence-detector step engine across N_CH serial channels,
// with per-channel saved state and saturating hit counters. Honors SEQ_DET_OVERLAP_EN via seq_det_core.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int               N_CH    = 4,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 8,
    localparam int              CH_W    = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_valid,
    input  logic [N_CH-1:0]  ch_bit,
    input  logic [N_CH-1:0]  ch_clr,
    output logic [N_CH-1:0]  ch_ready,
    output logic             det_valid,
    output logic [CH_W-1:0]  det_ch,
    output logic             det_hit,
    input  logic [CH_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    logic [ST_W-1:0]  st_q  [N_CH];
    logic [ST_W-1:0]  st_d  [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             det_valid_q, det_valid_d;
    logic             det_hit_q, det_hit_d;
    logic [CH_W-1:0]  det_ch_q, det_ch_d;

    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  grant;
    logic             gnt_any;
    logic [CH_W-1:0]  gnt_idx;
    logic [CH_W-1:0]  scan_idx;
    logic [ST_W-1:0]  eng_st, eng_next;
    logic             eng_bit, eng_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] v);
        return (v == CH_W'(N_CH - 1)) ? '0 : v + 1'b1;
    endfunction

    // A channel being cleared is never granted, so its held bit survives the clear
    always_comb begin
        elig     = ch_valid & ~ch_clr;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_idx = CH_W'((int'(rr_ptr_q) + i) % N_CH);
            if (!gnt_any && elig[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        grant = gnt_any ? (N_CH'(1) << gnt_idx) : '0;
    end

    assign ch_ready = grant;
    assign eng_st   = st_q[gnt_idx];
    assign eng_bit  = ch_bit[gnt_idx];

    seq_det_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .st      (eng_st),
        .bit_in  (eng_bit),
        .next_st (eng_next),
        .hit     (eng_hit)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign st_d[k]  = ch_clr[k] ? '0 : (grant[k] ? eng_next : st_q[k]);
        assign cnt_d[k] = ch_clr[k] ? '0 :
                          ((grant[k] && eng_hit) ? sat_inc(cnt_q[k]) : cnt_q[k]);
    end

    always_comb begin
        det_valid_d = gnt_any;
        det_hit_d   = gnt_any & eng_hit;
        det_ch_d    = gnt_any ? gnt_idx : det_ch_q;
        rr_ptr_d    = gnt_any ? wrap_inc(gnt_idx) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= '{default: '0};
            cnt_q       <= '{default: '0};
            rr_ptr_q    <= '0;
            det_valid_q <= 1'b0;
            det_hit_q   <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            det_valid_q <= det_valid_d;
            det_hit_q   <= det_hit_d;
            det_ch_q    <= det_ch_d;
        end
    end

    assign det_valid = det_valid_q;
    assign det_hit   = det_hit_q;
    assign det_ch    = det_ch_q;
    assign cnt_out   = cnt_q[cnt_sel];

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: directed literal checks plus randomized traffic against a
// bit-history reference model. Expectations follow SEQ_DET_OVERLAP_EN when defined.
module tb_seq_det_sched;

    localparam int         N_CH  = 4;
    localparam int         CNT_W = 8;
    localparam logic [3:0] PAT   = 4'b1101;
    localparam int         CMAX  = (1 << CNT_W) - 1;
`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_valid, ch_bit, ch_clr, ch_ready;
    logic       det_valid, det_hit;
    logic [1:0] det_ch, cnt_sel;
    logic [7:0] cnt_out;

    always #5 clk = ~clk;

    seq_det_sched #(
        .N_CH    (N_CH),
        .PAT_W   (4),
        .PATTERN (PAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_valid  (ch_valid),
        .ch_bit    (ch_bit),
        .ch_clr    (ch_clr),
        .ch_ready  (ch_ready),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_hit   (det_hit),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out)
    );

    int         nchk = 0;
    int         nerr = 0;
    bit         chk_en = 1'b0;
    logic [3:0] rdy_s;
    logic [3:0] ord [5];

    // Reference model: per channel, the bits received since the last restart
    int   m_hist [4];
    int   m_nb   [4];
    int   m_cnt  [4];
    int   m_ptr;
    int   m_dch;
    logic m_dv, m_dhit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int exp_grant(input logic [3:0] v, input logic [3:0] c, input int ptr);
        logic [3:0] e;
        int         idx;
        e = v & ~c;
        for (int i = 0; i < N_CH; i++) begin
            idx = (ptr + i) % N_CH;
            if (bit_of(32'(e), idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_hist[k] = 0;
            m_nb[k]   = 0;
            m_cnt[k]  = 0;
        end
        m_ptr  = 0;
        m_dch  = 0;
        m_dv   = 1'b0;
        m_dhit = 1'b0;
    endtask

    task automatic model_step();
        int   g;
        logic hit;
        g   = exp_grant(ch_valid, ch_clr, m_ptr);
        hit = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (bit_of(32'(ch_clr), k)) begin
                m_hist[k] = 0;
                m_nb[k]   = 0;
                m_cnt[k]  = 0;
            end
        end
        if (g >= 0) begin
            m_hist[g] = ((m_hist[g] << 1) | (bit_of(32'(ch_bit), g) ? 1 : 0)) & 15;
            m_nb[g]   = m_nb[g] + 1;
            hit       = (m_nb[g] >= 4) && (m_hist[g] == int'(PAT));
            if (hit) begin
                if (m_cnt[g] < CMAX) m_cnt[g] = m_cnt[g] + 1;
                if (!OVL) m_nb[g] = 0;
            end
            m_dv   = 1'b1;
            m_dch  = g;
            m_dhit = hit;
            m_ptr  = (g + 1) % N_CH;
        end else begin
            m_dv   = 1'b0;
            m_dhit = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    initial begin
        int         g;
        logic [3:0] er;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                g  = exp_grant(ch_valid, ch_clr, m_ptr);
                er = (g < 0) ? 4'h0 : 4'(1 << g);
                chk("m_ready", 32'(ch_ready), 32'(er));
                chk("m_det_valid", 32'(det_valid), 32'(m_dv));
                chk("m_det_ch", 32'(det_ch), 32'(m_dch));
                chk("m_det_hit", 32'(det_hit), 32'(m_dhit));
                chk("m_cnt_out", 32'(cnt_out), 32'(m_cnt[cnt_sel]));
            end
        end
    end

    task automatic cyc(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        ch_valid = v;
        ch_bit   = b;
        ch_clr   = c;
        #1;
        rdy_s = ch_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] s7;
        logic [6:0] h7;
        logic [3:0] q0;
        logic [4:0] q1;
        logic [3:0] v, b;
        int         i0, i1;

        ord = '{4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
        rst = 1'b0;
        ch_valid = '0;
        ch_bit   = '0;
        ch_clr   = '0;
        cnt_sel  = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        chk("rst_det_valid", 32'(det_valid), 0);
        chk("rst_det_ch", 32'(det_ch), 0);
        chk("rst_det_hit", 32'(det_hit), 0);
        chk("rst_ready", 32'(ch_ready), 0);
        for (int k = 0; k < N_CH; k++) begin
            cnt_sel = 2'(k);
            #1;
            chk("rst_cnt", 32'(cnt_out), 0);
        end
        @(posedge clk);
        #1;

        // Ch0 alone: 1,1,0,1,1,0,1
        s7 = 7'b1101101;
        h7 = OVL ? 7'b0001001 : 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            cyc(4'b0001, {3'b000, bit_of(32'(s7), 6 - i)}, 4'b0000);
            chk("ch0_ready", 32'(rdy_s), 1);
            chk("ch0_det_valid", 32'(det_valid), 1);
            chk("ch0_det_ch", 32'(det_ch), 0);
            chk("ch0_det_hit", 32'(det_hit), 32'(bit_of(32'(h7), 6 - i)));
        end
        cyc(4'b0000, 4'b0000, 4'b0000);
        chk("ch0_idle_valid", 32'(det_valid), 0);
        cnt_sel = 2'd0;
        #1;
        chk("ch0_cnt", 32'(cnt_out), OVL ? 2 : 1);

        // Bring rr_ptr to 0, then clear every channel
        cyc(4'b1000, 4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000, 4'b1111);

        // Ch0 sends 1101 while ch1 sends 01101, both held until consumed
        q0 = 4'b1101;
        q1 = 5'b01101;
        i0 = 0;
        i1 = 0;
        for (int t = 0; t < 9; t++) begin
            v = {2'b00, (i1 < 5), (i0 < 4)};
            b = {2'b00, bit_of(32'(q1), 4 - i1), bit_of(32'(q0), 3 - i0)};
            cyc(v, b, 4'b0000);
            chk("pair_ready", 32'(rdy_s), (t < 8) ? ((t % 2 == 1) ? 2 : 1) : 2);
            chk("pair_det_ch", 32'(det_ch), (t < 8) ? (t % 2) : 1);
            chk("pair_det_hit", 32'(det_hit), (t == 6 || t == 8) ? 1 : 0);
            if (rdy_s[0]) i0++;
            if (rdy_s[1]) i1++;
        end
        cyc(4'b0000, 4'b0000, 4'b0000);
        cnt_sel = 2'd0;
        #1;
        chk("pair_cnt0", 32'(cnt_out), 1);
        cnt_sel = 2'd1;
        #1;
        chk("pair_cnt1", 32'(cnt_out), 1);
        @(posedge clk);
        #1;

        // rr_ptr is now 2: all four valid
        for (int t = 0; t < 5; t++) begin
            cyc(4'b1111, 4'b0000, 4'b0000);
            chk("rr_order", 32'(rdy_s), 32'(ord[t]));
        end

        // Ch1 to S110, then clear it while it offers a bit
        cyc(4'b0010, 4'b0010, 4'b0000);
        cyc(4'b0010, 4'b0010, 4'b0000);
        cyc(4'b0010, 4'b0000, 4'b0000);
        cnt_sel = 2'd1;
        #1;
        chk("clr_cnt_before", 32'(cnt_out), 1);
        @(posedge clk);
        #1;
        cyc(4'b0010, 4'b0010, 4'b0010);
        chk("clr_ready", 32'(rdy_s), 0);
        chk("clr_det_valid", 32'(det_valid), 0);
        chk("clr_cnt_after", 32'(cnt_out), 0);
        cyc(4'b0010, 4'b0010, 4'b0000);
        chk("clr_first_valid", 32'(det_valid), 1);
        chk("clr_first_hit", 32'(det_hit), 0);
        cyc(4'b0010, 4'b0010, 4'b0000);
        chk("clr_s11_hit", 32'(det_hit), 0);
        cyc(4'b0010, 4'b0000, 4'b0000);
        chk("clr_s110_hit", 32'(det_hit), 0);
        cyc(4'b0010, 4'b0010, 4'b0000);
        chk("clr_match_hit", 32'(det_hit), 1);
        chk("clr_cnt_end", 32'(cnt_out), 1);
        cyc(4'b0000, 4'b0000, 4'b0000);

        // Randomized traffic, checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            ch_valid = 4'($urandom);
            ch_bit   = 4'($urandom);
            ch_clr   = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
            cnt_sel  = 2'($urandom);
            @(posedge clk);
            #1;
        end

        // Counter saturation on ch2
        cnt_sel = 2'd2;
        cyc(4'b0000, 4'b0000, 4'b1111);
        for (int r = 0; r < 260; r++) begin
            for (int i = 0; i < 4; i++) begin
                cyc(4'b0100, {1'b0, bit_of(32'(PAT), 3 - i), 2'b00}, 4'b0000);
            end
            if (r == 2) chk("sat_cnt_early", 32'(cnt_out), 3);
        end
        chk("sat_cnt", 32'(cnt_out), 255);

        // Asynchronous reset in the middle of a stream
        ch_valid = 4'b0100;
        ch_bit   = 4'b0100;
        ch_clr   = 4'b0000;
        #1 rst = 1'b0;
        #1;
        chk("arst_det_valid", 32'(det_valid), 0);
        chk("arst_det_ch", 32'(det_ch), 0);
        chk("arst_cnt", 32'(cnt_out), 0);
        @(posedge clk);
        #1;
        chk("arst_hold_valid", 32'(det_valid), 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_resume_ch", 32'(det_ch), 2);
        chk("arst_resume_hit", 32'(det_hit), 0);
        ch_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
